// File: rtl/muldiv_unit_p.sv
// Iterative multiply/divide peripheral: shift-add multiply, restoring divide,
// optional two's-complement handling via magnitude conversion and a sign-fix cycle.
module muldiv_unit_p #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(2*W)+1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] dbus_wdata,
    input  logic         cn_wctrl,
    input  logic         ar_wctrl,
    input  logic         br_wctrl,
    input  logic         hr_wctrl,
    input  logic         cr_wctrl,
    output logic [W-1:0] muldiv_cn,
    output logic [W-1:0] muldiv_ar,
    output logic [W-1:0] muldiv_br,
    output logic [W-1:0] muldiv_hr,
    output logic [W-1:0] muldiv_cr,
    output logic         muldiv_int,
    output logic         muldiv_busy
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nx;
    logic [W-1:0]     ar, br, hr, cr;
    logic [CNT_W-1:0] cnt, last;
    logic             ie, f, sg, md, dz;
    logic [1:0]       sm;
    logic             neg_q, neg_r, dz_pend;

    logic [W-1:0]     a_in, b_in, h_in;
    logic             eff_md, eff_sg, start_req, dz_start, abort, done_run, busy;
    logic [2*W-1:0]   mul_add, mul_acc;
    logic [W-1:0]     cr_sh, div_rem;
    logic             div_ge;
    logic [W-1:0]     cn_v;

    function automatic logic [W-1:0] mag_w(input logic signed [W-1:0] v);
        return v[W-1] ? W'(-v) : W'(v);
    endfunction

    function automatic logic [2*W-1:0] mag_2w(input logic signed [2*W-1:0] v);
        return v[2*W-1] ? (2*W)'(-v) : (2*W)'(v);
    endfunction

    function automatic logic [W-1:0] neg_w(input logic signed [W-1:0] v);
        return W'(-v);
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic signed [2*W-1:0] v);
        return (2*W)'(-v);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        a_in      = ar_wctrl ? dbus_wdata : ar;
        b_in      = br_wctrl ? dbus_wdata : br;
        h_in      = hr_wctrl ? dbus_wdata : hr;
        eff_md    = cn_wctrl ? dbus_wdata[3] : md;
        eff_sg    = cn_wctrl ? dbus_wdata[4] : sg;
        busy      = (state != IDLE);
        start_req = (state == IDLE) &&
                    ((cn_wctrl && dbus_wdata[5]) || (ar_wctrl && sm == 2'd1) ||
                     (br_wctrl && sm == 2'd2) || (hr_wctrl && sm == 2'd3));
        dz_start  = start_req && eff_md && (a_in == '0);
        abort     = busy && cn_wctrl && !dbus_wdata[5];
        last      = md ? CNT_W'(2*W-1) : CNT_W'(W-1);
        done_run  = (state == RUN) && (cnt == last);
        state_nx  = state;
        unique case (state)
            IDLE: if (start_req) state_nx = dz_start ? FIX : RUN;
            RUN: begin
                if (abort)         state_nx = IDLE;
                else if (done_run) state_nx = sg ? FIX : IDLE;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One multiply step: MSB-first shift-add, BR rotates back to its start value after W steps.
    always_comb begin
        mul_add = br[W-1] ? {{W{1'b0}}, ar} : '0;
        mul_acc = {hr[W-2:0], cr, 1'b0} + mul_add;
        // A set CR MSB means the shifted partial remainder exceeds any W-bit divisor.
        cr_sh   = {cr[W-2:0], hr[W-1]};
        div_ge  = cr[W-1] || (cr_sh >= ar);
        div_rem = div_ge ? (cr_sh - ar) : cr_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar <= '0; br <= '0; hr <= '0; cr <= '0; cnt <= '0;
            ie <= 1'b0; f <= 1'b0; sg <= 1'b0; md <= 1'b0; dz <= 1'b0; sm <= 2'd0;
            neg_q <= 1'b0; neg_r <= 1'b0; dz_pend <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cn_wctrl) begin
                        ie <= dbus_wdata[7]; f  <= dbus_wdata[6]; sg <= dbus_wdata[4];
                        md <= dbus_wdata[3]; sm <= dbus_wdata[1:0];
                    end
                    if (ar_wctrl) ar <= dbus_wdata;
                    if (br_wctrl) br <= dbus_wdata;
                    if (hr_wctrl) hr <= dbus_wdata;
                    if (cr_wctrl) cr <= dbus_wdata;
                    if (start_req) begin
                        f <= 1'b0; dz <= 1'b0; cr <= '0; cnt <= '0; dz_pend <= dz_start;
                        if (eff_md) begin
                            neg_q    <= eff_sg && (h_in[W-1] ^ a_in[W-1]);
                            neg_r    <= eff_sg && h_in[W-1];
                            {hr, br} <= eff_sg ? mag_2w({h_in, b_in}) : {h_in, b_in};
                            ar       <= eff_sg ? mag_w(a_in) : a_in;
                        end else begin
                            neg_q <= eff_sg && (a_in[W-1] ^ b_in[W-1]);
                            neg_r <= 1'b0;
                            hr    <= '0;
                            ar    <= eff_sg ? mag_w(a_in) : a_in;
                            br    <= eff_sg ? mag_w(b_in) : b_in;
                        end
                    end
                end
                RUN: begin
                    if (cn_wctrl) begin
                        ie <= dbus_wdata[7]; f <= dbus_wdata[6];
                    end
                    if (!abort) begin
                        cnt <= cnt + 1'b1;
                        if (md) begin
                            {hr, br} <= {hr[W-2:0], br, div_ge};
                            cr       <= div_rem;
                        end else begin
                            {hr, cr} <= mul_acc;
                            br       <= {br[W-2:0], br[W-1]};
                        end
                        if (done_run && !sg) f <= 1'b1;
                    end
                end
                FIX: begin
                    if (cn_wctrl) begin
                        ie <= dbus_wdata[7]; f <= dbus_wdata[6];
                    end
                    if (!abort) begin
                        f <= 1'b1;
                        if (dz_pend) begin
                            hr <= '1; br <= '1; cr <= '0; dz <= 1'b1;
                        end else if (md) begin
                            if (neg_q) {hr, br} <= neg_2w({hr, br});
                            if (neg_r) cr <= neg_w(cr);
                        end else if (neg_q) begin
                            {hr, cr} <= neg_2w({hr, cr});
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cn_v      = '0;
        cn_v[7:0] = {ie, f, busy, sg, md, dz, sm};
    end

    assign muldiv_cn   = cn_v;
    assign muldiv_ar   = ar;
    assign muldiv_br   = br;
    assign muldiv_hr   = hr;
    assign muldiv_cr   = cr;
    assign muldiv_int  = f & ie;
    assign muldiv_busy = busy;
endmodule

// File: tb/tb_muldiv_unit_p.sv
// Self-checking bench for muldiv_unit_p (W=8): directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_unit_p;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dbus_wdata = '0;
    logic       cn_wctrl = 1'b0, ar_wctrl = 1'b0, br_wctrl = 1'b0, hr_wctrl = 1'b0, cr_wctrl = 1'b0;
    logic [7:0] muldiv_cn, muldiv_ar, muldiv_br, muldiv_hr, muldiv_cr;
    logic       muldiv_int, muldiv_busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    muldiv_unit_p #(.W(8)) dut (
        .clk(clk), .rst(rst), .dbus_wdata(dbus_wdata),
        .cn_wctrl(cn_wctrl), .ar_wctrl(ar_wctrl), .br_wctrl(br_wctrl),
        .hr_wctrl(hr_wctrl), .cr_wctrl(cr_wctrl),
        .muldiv_cn(muldiv_cn), .muldiv_ar(muldiv_ar), .muldiv_br(muldiv_br),
        .muldiv_hr(muldiv_hr), .muldiv_cr(muldiv_cr),
        .muldiv_int(muldiv_int), .muldiv_busy(muldiv_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cnw(input logic ie, input logic f, input logic st,
                                       input logic sg, input logic md, input logic [1:0] sm);
        return {ie, f, st, sg, md, 1'b0, sm};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // sel: 0=CN 1=AR 2=BR 3=HR 4=CR
    task automatic wr(input int sel, input logic [7:0] v);
        dbus_wdata = v;
        cn_wctrl = (sel == 0); ar_wctrl = (sel == 1); br_wctrl = (sel == 2);
        hr_wctrl = (sel == 3); cr_wctrl = (sel == 4);
        tick();
        cn_wctrl = 0; ar_wctrl = 0; br_wctrl = 0; hr_wctrl = 0; cr_wctrl = 0;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] b, input logic [7:0] a);
        wr(0, cnw(0, 0, 0, 0, 0, 2'd0));
        wr(3, h); wr(2, b); wr(1, a);
    endtask

    task automatic test_reset();
        rst = 1; tick(); rst = 0;
        n_cmp++; if (muldiv_cn !== 8'h00) begin n_bad++; $display("FAIL reset_cn got %h want 00", muldiv_cn); end
        n_cmp++; if (muldiv_ar !== 8'h00) begin n_bad++; $display("FAIL reset_ar got %h want 00", muldiv_ar); end
        n_cmp++; if (muldiv_br !== 8'h00) begin n_bad++; $display("FAIL reset_br got %h want 00", muldiv_br); end
        n_cmp++; if (muldiv_hr !== 8'h00) begin n_bad++; $display("FAIL reset_hr got %h want 00", muldiv_hr); end
        n_cmp++; if (muldiv_cr !== 8'h00) begin n_bad++; $display("FAIL reset_cr got %h want 00", muldiv_cr); end
        n_cmp++; if ({muldiv_int, muldiv_busy} !== 2'b00) begin n_bad++; $display("FAIL reset_int_busy got %b want 00", {muldiv_int, muldiv_busy}); end
    endtask

    task automatic test_mul_unsigned();
        load(8'h00, 8'h64, 8'hC8);
        wr(0, cnw(0, 0, 1, 0, 0, 2'd0));
        repeat (7) tick();
        n_cmp++; if (muldiv_busy !== 1'b1) begin n_bad++; $display("FAIL umul_busy7 got %b want 1", muldiv_busy); end
        tick();
        n_cmp++; if ({muldiv_hr, muldiv_cr} !== 16'h4E20) begin n_bad++; $display("FAIL umul_result got %h want 4e20", {muldiv_hr, muldiv_cr}); end
        n_cmp++; if ({muldiv_cn[6], muldiv_busy} !== 2'b10) begin n_bad++; $display("FAIL umul_f_busy got %b want 10", {muldiv_cn[6], muldiv_busy}); end
        n_cmp++; if (muldiv_br !== 8'h64) begin n_bad++; $display("FAIL umul_br_hold got %h want 64", muldiv_br); end
    endtask

    task automatic test_div_unsigned();
        load(8'h12, 8'h34, 8'h10);
        wr(0, cnw(0, 0, 1, 0, 1, 2'd0));
        repeat (15) tick();
        n_cmp++; if (muldiv_busy !== 1'b1) begin n_bad++; $display("FAIL udiv_busy15 got %b want 1", muldiv_busy); end
        tick();
        n_cmp++; if ({muldiv_hr, muldiv_br, muldiv_cr} !== 24'h012304) begin n_bad++; $display("FAIL udiv_result got %h want 012304", {muldiv_hr, muldiv_br, muldiv_cr}); end
        n_cmp++; if ({muldiv_cn[6], muldiv_busy} !== 2'b10) begin n_bad++; $display("FAIL udiv_f_busy got %b want 10", {muldiv_cn[6], muldiv_busy}); end
    endtask

    task automatic test_signed();
        load(8'h00, 8'h05, 8'hFD);
        wr(0, cnw(0, 0, 1, 1, 0, 2'd0));
        repeat (8) tick();
        n_cmp++; if (muldiv_busy !== 1'b1) begin n_bad++; $display("FAIL smul_busy8 got %b want 1", muldiv_busy); end
        tick();
        n_cmp++; if ({muldiv_hr, muldiv_cr, muldiv_cn[6]} !== {16'hFFF1, 1'b1}) begin n_bad++; $display("FAIL smul_result got %h f=%b want fff1 f=1", {muldiv_hr, muldiv_cr}, muldiv_cn[6]); end
        load(8'hFF, 8'h9C, 8'h07);
        wr(0, cnw(0, 0, 1, 1, 1, 2'd0));
        repeat (16) tick();
        n_cmp++; if (muldiv_busy !== 1'b1) begin n_bad++; $display("FAIL sdiv_busy16 got %b want 1", muldiv_busy); end
        tick();
        n_cmp++; if ({muldiv_hr, muldiv_br, muldiv_cr, muldiv_cn[6]} !== {24'hFFF2FE, 1'b1}) begin n_bad++; $display("FAIL sdiv_result got %h f=%b want fff2fe f=1", {muldiv_hr, muldiv_br, muldiv_cr}, muldiv_cn[6]); end
    endtask

    task automatic test_overflow();
        load(8'h80, 8'h00, 8'hFF);
        wr(0, cnw(0, 0, 1, 1, 1, 2'd0));
        repeat (17) tick();
        n_cmp++; if ({muldiv_hr, muldiv_br, muldiv_cr} !== 24'h800000 || muldiv_cn !== 8'h58) begin n_bad++; $display("FAIL sdiv_wrap got %h cn=%h want 800000 cn=58", {muldiv_hr, muldiv_br, muldiv_cr}, muldiv_cn); end
    endtask

    task automatic test_div_zero();
        load(8'h12, 8'h34, 8'h00);
        wr(0, cnw(1, 0, 1, 0, 1, 2'd0));
        tick();
        n_cmp++; if (muldiv_cn !== 8'hCC || muldiv_int !== 1'b1) begin n_bad++; $display("FAIL dz_flags got cn=%h int=%b want cn=cc int=1", muldiv_cn, muldiv_int); end
        n_cmp++; if ({muldiv_hr, muldiv_br, muldiv_cr} !== 24'hFFFF00) begin n_bad++; $display("FAIL dz_regs got %h want ffff00", {muldiv_hr, muldiv_br, muldiv_cr}); end
    endtask

    task automatic test_busy_abort();
        wr(0, cnw(0, 0, 0, 0, 0, 2'd2));
        wr(1, 8'h11);
        n_cmp++; if (muldiv_busy !== 1'b0) begin n_bad++; $display("FAIL ar_write_no_start got busy=%b want 0", muldiv_busy); end
        wr(2, 8'h22);
        tick(); tick();
        wr(1, 8'h99);
        tick();
        n_cmp++; if (muldiv_busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %b want 1", muldiv_busy); end
        wr(0, cnw(0, 0, 0, 0, 0, 2'd2));
        n_cmp++; if ({muldiv_busy, muldiv_cn[6]} !== 2'b00) begin n_bad++; $display("FAIL abort_busy_f got %b want 00", {muldiv_busy, muldiv_cn[6]}); end
        n_cmp++; if (muldiv_ar !== 8'h11) begin n_bad++; $display("FAIL busy_ar_ignored got %h want 11", muldiv_ar); end
    endtask

    task automatic test_reset_mid();
        load(8'h12, 8'h34, 8'h10);
        wr(0, cnw(1, 0, 1, 0, 1, 2'd0));
        repeat (3) tick();
        rst = 1; ar_wctrl = 1; dbus_wdata = 8'h55;
        tick();
        rst = 0; ar_wctrl = 0;
        n_cmp++; if ({muldiv_cn, muldiv_ar, muldiv_br, muldiv_hr, muldiv_cr} !== 40'h0 || {muldiv_int, muldiv_busy} !== 2'b00) begin
            n_bad++; $display("FAIL rst_mid got %h int=%b busy=%b want all 0", {muldiv_cn, muldiv_ar, muldiv_br, muldiv_hr, muldiv_cr}, muldiv_int, muldiv_busy); end
        load(8'h12, 8'h34, 8'h10);
        wr(0, cnw(0, 0, 1, 0, 1, 2'd0));
        repeat (16) tick();
        n_cmp++; if ({muldiv_hr, muldiv_br, muldiv_cr, muldiv_cn[6]} !== {24'h012304, 1'b1}) begin n_bad++; $display("FAIL rst_rerun got %h f=%b want 012304 f=1", {muldiv_hr, muldiv_br, muldiv_cr}, muldiv_cn[6]); end
    endtask

    task automatic test_cr_write();
        wr(0, cnw(0, 0, 0, 0, 0, 2'd0));
        wr(4, 8'h5A);
        n_cmp++; if (muldiv_cr !== 8'h5A) begin n_bad++; $display("FAIL cr_write got %h want 5a", muldiv_cr); end
        dbus_wdata = cnw(0, 0, 1, 0, 0, 2'd0); cn_wctrl = 1; cr_wctrl = 1;
        tick();
        cn_wctrl = 0; cr_wctrl = 0;
        n_cmp++; if ({muldiv_cr, muldiv_busy} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL cr_start_prio got cr=%h busy=%b want cr=00 busy=1", muldiv_cr, muldiv_busy); end
        wr(0, cnw(0, 0, 0, 0, 0, 2'd0));
    endtask

    task automatic test_f_priority();
        load(8'h00, 8'h03, 8'h05);
        wr(0, cnw(0, 0, 1, 0, 0, 2'd0));
        repeat (7) tick();
        wr(0, cnw(1, 0, 1, 0, 0, 2'd0));
        n_cmp++; if ({muldiv_cn[6], muldiv_int, muldiv_busy} !== 3'b110) begin n_bad++; $display("FAIL f_prio got f,int,busy=%b want 110", {muldiv_cn[6], muldiv_int, muldiv_busy}); end
        n_cmp++; if ({muldiv_hr, muldiv_cr} !== 16'h000F) begin n_bad++; $display("FAIL f_prio_prod got %h want 000f", {muldiv_hr, muldiv_cr}); end
        wr(0, cnw(1, 0, 0, 0, 0, 2'd0));
        n_cmp++; if ({muldiv_cn[6], muldiv_int} !== 2'b00) begin n_bad++; $display("FAIL f_clear got f,int=%b want 00", {muldiv_cn[6], muldiv_int}); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  a, b, h, eh, eb, ec, ecn;
            logic [15:0] dd16;
            logic        sg, md, dzx, early;
            int          q, r, p, lat;
            a = 8'($urandom); b = 8'($urandom); h = 8'($urandom);
            sg = 1'($urandom); md = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'h00;
            dd16 = {h, b};
            dzx = md && (a == 8'h00);
            eh = h; eb = b; ec = 8'h00;
            if (dzx) begin
                eh = 8'hFF; eb = 8'hFF; ec = 8'h00; lat = 1;
            end else if (md) begin
                if (sg) begin q = int'($signed(dd16)) / int'($signed(a)); r = int'($signed(dd16)) % int'($signed(a)); end
                else    begin q = int'(dd16) / int'(a); r = int'(dd16) % int'(a); end
                eh = q[15:8]; eb = q[7:0]; ec = r[7:0]; lat = sg ? 17 : 16;
            end else begin
                if (sg) p = int'($signed(a)) * int'($signed(b));
                else    p = int'(a) * int'(b);
                eh = p[15:8]; ec = p[7:0]; lat = sg ? 9 : 8;
            end
            ecn = {1'b0, 1'b1, 1'b0, sg, md, dzx, 2'd0};
            load(h, b, a);
            wr(0, cnw(0, 0, 1, sg, md, 2'd0));
            early = 1'b0;
            for (int k = 1; k < lat; k++) begin
                if (muldiv_cn[6] !== 1'b0 || muldiv_busy !== 1'b1) early = 1'b1;
                tick();
            end
            if (muldiv_cn[6] !== 1'b0 || muldiv_busy !== 1'b1) early = 1'b1;
            tick();
            n_cmp++; if (early) begin n_bad++; $display("FAIL rnd_latency op%0d got early finish want %0d cycles", i, lat); end
            n_cmp++; if (muldiv_cn !== ecn) begin n_bad++; $display("FAIL rnd_cn op%0d got %h want %h", i, muldiv_cn, ecn); end
            n_cmp++; if (muldiv_hr !== eh || muldiv_cr !== ec) begin n_bad++; $display("FAIL rnd_hr_cr op%0d a=%h b=%h h=%h sg=%b md=%b got %h%h want %h%h", i, a, b, h, sg, md, muldiv_hr, muldiv_cr, eh, ec); end
            if (md || !sg) begin
                n_cmp++; if (muldiv_br !== eb) begin n_bad++; $display("FAIL rnd_br op%0d got %h want %h", i, muldiv_br, eb); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_unsigned();
        test_div_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_busy_abort();
        test_reset_mid();
        test_cr_write();
        test_f_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit_p.md
MULDIV_UNIT_P -- requirements
Module: muldiv_unit_p

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width in bits; legal W >= 8.
REQ-002 SHALL have parameter CNT_W, default $clog2(2*W)+1, meaning iteration counter width.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dbus_wdata  input  W  register write data.
REQ-006 SHALL have ports cn_wctrl, ar_wctrl, br_wctrl, hr_wctrl, cr_wctrl  input  1 each  single-cycle write strobes for CN, AR, BR, HR and CR.
REQ-007 SHALL have ports muldiv_cn  output  W  control/status as {zeros, ie, f, busy, sg, md, dz, sm[1:0]}, where ie is bit 7 and sm is bits 1:0.
REQ-008 SHALL have ports muldiv_ar, muldiv_br, muldiv_hr, muldiv_cr  output  W each  register contents.
REQ-009 SHALL have port muldiv_int  output  1  equal to f & ie.
REQ-010 SHALL have port muldiv_busy  output  1  high while an operation is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and FIX; busy is high in RUN and FIX.
REQ-012 SHALL take its CN write fields from dbus_wdata: ie=[7], f=[6], sg=[4], md=[3], sm=[1:0]; bit [5]=1 is a start command and bit [5]=0 is an abort/no-op.
REQ-013 SHALL start an operation from IDLE on any of: a CN write with bit5=1; an AR write with sm=1; a BR write with sm=2; an HR write with sm=3.
REQ-014 SHALL, at the start edge, clear f and dz, clear CR, load counter=0 and enter RUN, using the value written in the same cycle for any operand written then.
REQ-015 SHALL, when md=0 (multiply), produce {HR,CR}=AR*BR, 2W bits, after W RUN cycles; BR holds its start value at completion.
REQ-016 SHALL, when md=1 (divide), take dividend {HR,BR} (2W bits) and divisor AR; after 2W RUN cycles, quotient is in {HR,BR} and remainder is in CR.
REQ-017 SHALL, when sg=1, treat operands as two's complement, convert them to magnitudes at the start edge and spend one FIX cycle after RUN applying signs.
REQ-018 SHALL, in FIX, negate the product if the operand signs differ, negate the quotient if the signs differ, and give the remainder the sign of the dividend.
REQ-019 SHALL, when sg=0, skip FIX; unsigned latency is W cycles (mul) or 2W cycles (div) from start edge to f=1 visible.
REQ-020 SHALL wrap the signed divide -2^(2W-1)/-1 modulo 2^(2W) with no flag.
REQ-021 SHALL, on a divide start with AR=0 (divisor at the start edge), skip RUN: next edge sets dz=1, f=1 and {HR,BR}=all ones, CR=0, returning to IDLE.
REQ-022 SHALL, at completion, set f=1, return to IDLE, hold the results and keep ie, sg, md and sm.
REQ-023 SHALL, on a CN write with bit5=0 while busy, abort: return to IDLE next edge with f unchanged and register contents left as partial values.
REQ-024 SHALL ignore AR, BR, HR and CR writes and start commands while busy; CN writes while busy update only ie and f, plus abort per REQ-023.
REQ-025 SHALL, when a software write to f and completion occur in the same edge, give the completion priority (f=1).
REQ-026 SHALL, in IDLE, accept a CR write, storing dbus_wdata to CR; start clearing of CR has priority over a simultaneous CR write.

Reset
REQ-027 SHALL, when rst is high at a clock edge, force IDLE, clear all registers, counter and fields, and drive muldiv_cn=0, muldiv_int=0 and muldiv_busy=0.
REQ-028 SHALL, on reset mid-operation, abandon the operation with no completion flag.
REQ-029 SHALL give rst priority over all write strobes.

Verification
REQ-030 SHALL be verified, W=8, by: unsigned mul AR=0xC8, BR=0x64, CN start md=0 -> after 8 cycles HR=0x4E, CR=0x20, f=1, busy=0.
REQ-031 SHALL be verified by: unsigned div HR=0x12, BR=0x34, AR=0x10, md=1 -> after 16 cycles HR=0x01, BR=0x23, CR=0x04, f=1.
REQ-032 SHALL be verified by: signed mul AR=0xFD, BR=0x05, sg=1 -> after 9 cycles HR=0xFF, CR=0xF1; signed div HR=0xFF, BR=0x9C, AR=0x07 -> after 17 cycles HR=0xFF, BR=0xF2, CR=0xFE.
REQ-033 SHALL be verified by: div start with AR=0x00, ie=1 -> next cycle dz=1, f=1, muldiv_int=1, HR=BR=0xFF, CR=0x00.
REQ-034 SHALL be verified by: sm=2, BR write starts a mul; an AR write at cycle 3 is ignored; a CN write bit5=0 at cycle 5 -> busy=0 next cycle, f=0.
REQ-035 SHALL be verified by: rst pulse at RUN cycle 4 of a divide -> all outputs 0 next cycle, and a fresh start then runs normally.
